// File: rtl/lane_swap_sequencer_if.sv
// rtl/lane_swap_sequencer_if.sv - word-in / lane-out stream bundle for the absorb front-end
// master drives words and accepts lanes; slave is the sequencer side.
interface lane_swap_sequencer_if #(
  parameter int IDX_W = 5
);
  logic             s_valid;
  logic             s_ready;
  logic [31:0]      s_data;
  logic             s_last;
  logic             m_valid;
  logic             m_ready;
  logic [63:0]      m_data;
  logic [IDX_W-1:0] m_idx;
  logic             m_block_last;
  logic             m_msg_last;

  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_data, m_idx, m_block_last, m_msg_last
  );

  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_data, m_idx, m_block_last, m_msg_last
  );
endinterface

// File: rtl/lane_swap_sequencer.sv
// rtl/lane_swap_sequencer.sv - packs 32-bit word pairs into framed, optionally byte-reversed 64-bit lanes
// Lane index runs per rate block and restarts at each message end.
module lane_swap_sequencer #(
  parameter int RATE_LANES = 21,
  parameter int IDX_W      = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_swap,
  lane_swap_sequencer_if.slave  bus,
  output logic                  busy
);

  typedef enum logic {LO = 1'b0, HI = 1'b1} state_t;

  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(RATE_LANES - 1);

  state_t           state;
  state_t           state_nx;
  logic [31:0]      lo_reg;
  logic             swap_lat;
  logic             msg_active;
  logic [IDX_W-1:0] idx_cnt;
  logic             accept;
  logic             load;
  logic             swap_eff;
  logic [63:0]      raw;
  logic [63:0]      lane_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LO;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    bus.s_ready = !bus.m_valid || bus.m_ready;
    accept      = bus.s_valid && bus.s_ready;
    state_nx    = state;
    load        = 1'b0;
    raw         = {32'h0, bus.s_data};
    case (state)
      LO: begin
        if (accept) begin
          if (bus.s_last) begin
            load = 1'b1;
          end else begin
            state_nx = HI;
          end
        end
      end
      HI: begin
        raw = {bus.s_data, lo_reg};
        if (accept) begin
          load     = 1'b1;
          state_nx = LO;
        end
      end
      default: state_nx = LO;
    endcase
    // a one-word message must already see this message's swap setting
    swap_eff  = (state == LO && !msg_active) ? cfg_swap : swap_lat;
    lane_data = swap_eff ? {<<8{raw}} : raw;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_reg           <= 32'h0;
      swap_lat         <= 1'b0;
      msg_active       <= 1'b0;
      idx_cnt          <= '0;
      bus.m_valid      <= 1'b0;
      bus.m_data       <= 64'h0;
      bus.m_idx        <= '0;
      bus.m_block_last <= 1'b0;
      bus.m_msg_last   <= 1'b0;
    end else begin
      if (accept && state == LO) begin
        lo_reg <= bus.s_data;
        if (!msg_active) begin
          swap_lat <= cfg_swap;
        end
      end
      if (accept) begin
        msg_active <= !bus.s_last;
      end
      if (load) begin
        bus.m_valid      <= 1'b1;
        bus.m_data       <= lane_data;
        bus.m_idx        <= idx_cnt;
        bus.m_block_last <= (idx_cnt == IDX_MAX);
        bus.m_msg_last   <= bus.s_last;
        if (bus.s_last || idx_cnt == IDX_MAX) begin
          idx_cnt <= '0;
        end else begin
          idx_cnt <= idx_cnt + 1'b1;
        end
      end else if (bus.m_ready) begin
        bus.m_valid <= 1'b0;
      end
    end
  end

  assign busy = msg_active || bus.m_valid;

endmodule

// File: tb/tb_lane_swap_sequencer.sv
// tb/tb_lane_swap_sequencer.sv - directed bench with a lane-queue model of the sequencer
// Expected lanes are built per message from the word list, then matched on every valid cycle.
module tb_lane_swap_sequencer;
  localparam int RATE = 21;

  typedef struct {
    logic [63:0] data;
    logic [4:0]  idx;
    logic        blast;
    logic        last;
  } lane_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cfg_swap = 1'b0;
  logic busy;

  int total = 0;
  int bad = 0;
  int stalls = 0;
  int lanes_seen = 0;
  int model_idx = 0;
  int seen_before;
  bit bp_done;
  logic [63:0] hold;
  lane_t exp_q[$];
  logic [31:0] words[$];

  lane_swap_sequencer_if #(.IDX_W(5)) bus ();

  lane_swap_sequencer #(.RATE_LANES(RATE), .IDX_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_swap(cfg_swap), .bus(bus), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] bswap(input logic [63:0] v);
    logic [63:0] r = 64'h0;
    for (int k = 0; k < 8; k++) r = (r << 8) | ((v >> (8 * k)) & 64'hFF);
    return r;
  endfunction

  task automatic model(input logic sw);
    int n = words.size();
    for (int i = 0; i < n; i += 2) begin
      lane_t e;
      logic [63:0] r;
      r[31:0]  = words[i];
      r[63:32] = (i + 1 < n) ? words[i+1] : 32'h0;
      e.data  = sw ? bswap(r) : r;
      e.idx   = 5'(model_idx);
      e.blast = (model_idx == RATE - 1);
      e.last  = (i + 2 >= n);
      exp_q.push_back(e);
      model_idx = e.last ? 0 : (model_idx + 1) % RATE;
    end
  endtask

  task automatic send(input logic sw, input bit toggle);
    int n = words.size();
    cfg_swap = sw;
    for (int i = 0; i < n; i++) begin
      int waits = 0;
      bus.s_valid = 1'b1;
      bus.s_data  = words[i];
      bus.s_last  = (i == n - 1);
      @(negedge clk);
      while (!bus.s_ready && waits < 500) begin
        waits++;
        @(negedge clk);
      end
      total++;
      if (waits >= 500) begin
        bad++;
        $display("FAIL beat_accept_timeout: beat %0d got no s_ready want s_ready", i);
      end
      @(posedge clk); #1;
      if (toggle && i == 0) cfg_swap = ~sw;
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while (exp_q.size() != 0 && w < 200) begin
      @(posedge clk); #1;
      w++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout: got %0d lanes left want 0", exp_q.size());
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.s_valid && !bus.s_ready) stalls++;
      if (bus.m_valid) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_lane: got %h want no lane", bus.m_data);
        end else begin
          chk("lane_data", bus.m_data, exp_q[0].data);
          chk("lane_idx", 64'(bus.m_idx), 64'(exp_q[0].idx));
          chk("lane_block_last", 64'(bus.m_block_last), 64'(exp_q[0].blast));
          chk("lane_msg_last", 64'(bus.m_msg_last), 64'(exp_q[0].last));
          chk("busy_with_lane", 64'(busy), 64'd1);
          if (bus.m_ready) begin
            void'(exp_q.pop_front());
            lanes_seen++;
          end
        end
      end
    end
  end

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data  = 32'h0;
    bus.s_last  = 1'b0;
    bus.m_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_m_valid", 64'(bus.m_valid), 64'd0);
    chk("rst_m_data", bus.m_data, 64'h0);
    chk("rst_m_idx", 64'(bus.m_idx), 64'd0);
    chk("rst_block_last", 64'(bus.m_block_last), 64'd0);
    chk("rst_msg_last", 64'(bus.m_msg_last), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_s_ready", 64'(bus.s_ready), 64'd1);

    words = '{32'h03020100, 32'h07060504};
    model(1'b1);
    send(1'b1, 1'b0);
    chk("swap_on_valid", 64'(bus.m_valid), 64'd1);
    chk("swap_on_data", bus.m_data, 64'h0001020304050607);
    chk("swap_on_idx", 64'(bus.m_idx), 64'd0);
    chk("swap_on_msg_last", 64'(bus.m_msg_last), 64'd1);
    chk("swap_on_block_last", 64'(bus.m_block_last), 64'd0);

    model(1'b0);
    send(1'b0, 1'b0);
    chk("swap_off_data", bus.m_data, 64'h0706050403020100);

    words = '{32'hAABBCCDD};
    model(1'b1);
    send(1'b1, 1'b0);
    chk("odd_data", bus.m_data, 64'hDDCCBBAA00000000);
    chk("odd_msg_last", 64'(bus.m_msg_last), 64'd1);

    words = '{32'h00000001, 32'h00000002};
    model(1'b0);
    send(1'b0, 1'b0);
    chk("after_odd_idx", 64'(bus.m_idx), 64'd0);
    drain();

    words.delete();
    for (int i = 0; i < 44; i++) words.push_back(32'h10000000 + 32'(i));
    model(1'b0);
    chk("model_lane20_idx", 64'(exp_q[20].idx), 64'd20);
    chk("model_lane20_blast", 64'(exp_q[20].blast), 64'd1);
    chk("model_lane21_idx", 64'(exp_q[21].idx), 64'd0);
    chk("model_lane21_last", 64'(exp_q[21].last), 64'd1);
    stalls = 0;
    seen_before = lanes_seen;
    send(1'b0, 1'b0);
    chk("wrap_input_stalls", 64'(stalls), 64'd0);
    drain();
    chk("wrap_lane_count", 64'(lanes_seen - seen_before), 64'd22);
    chk("idle_busy", 64'(busy), 64'd0);

    bus.m_ready = 1'b0;
    words = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    model(1'b0);
    bp_done = 1'b0;
    fork
      begin
        send(1'b0, 1'b0);
        bp_done = 1'b1;
      end
    join_none
    repeat (3) @(posedge clk);
    #1;
    chk("bp_valid", 64'(bus.m_valid), 64'd1);
    chk("bp_s_ready", 64'(bus.s_ready), 64'd0);
    hold = bus.m_data;
    chk("bp_first_lane", hold, 64'h2222222211111111);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk("bp_hold_data", bus.m_data, 64'h2222222211111111);
      chk("bp_hold_s_ready", 64'(bus.s_ready), 64'd0);
    end
    bus.m_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("bp_next_valid", 64'(bus.m_valid), 64'd1);
    chk("bp_next_data", bus.m_data, 64'h4444444433333333);
    for (int c = 0; c < 50 && !bp_done; c++) begin
      @(posedge clk); #1;
    end
    chk("bp_sender_done", 64'(bp_done), 64'd1);
    drain();

    bus.s_valid = 1'b1;
    bus.s_data  = 32'hDEADBEEF;
    bus.s_last  = 1'b0;
    @(posedge clk); #1;
    bus.s_valid = 1'b0;
    chk("mid_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(bus.m_valid), 64'd0);
    chk("mid_rst_data", bus.m_data, 64'h0);
    chk("mid_rst_idx", 64'(bus.m_idx), 64'd0);
    chk("mid_rst_msg_last", 64'(bus.m_msg_last), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    model_idx = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_quiet", 64'(bus.m_valid), 64'd0);

    words = '{32'h03020100, 32'h07060504};
    model(1'b1);
    send(1'b1, 1'b1);
    chk("toggle_data", bus.m_data, 64'h0001020304050607);
    chk("toggle_idx", 64'(bus.m_idx), 64'd0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
